rr_arbiter16: RTL and testbench
===============================

# rr_arbiter16

Round-robin arbiter that selects one of N requesters and holds a registered one-hot grant until the holder releases. It sits directly upstream of the 16:4 factored encoder and the one-hot-select multiplexers. Its grant vector is always zero or one-hot, so it can drive an encoder input or a one-hot mux select directly. It is used to time-share a single ALU operand path among several sources.

## Interface

Parameters:
- `N`, default 16: number of requesters; grant width. Must be 2–16.
- `IW`, default 4: index width; `2**IW >= N`.
- `MAX_HOLD`, default 15: hold-cycle limit. Used only when the timeout feature is compiled in. Range 1 to 2**8-1.

Ports:
- `clk`, input, 1: single clock; everything is rising-edge.
- `rst`, input, 1: reset. Synchronous, active-high.
- `req`, input, N: request vector; any number of bits may be set.
- `release`, input, 1: holder finished; sampled only in HOLD.
- `grant`, output, N: registered grant; all-zero or one-hot.
- `grant_valid`, output, 1: registered; equals `|grant`.
- `grant_idx`, output, IW: registered binary index of the granted requester; 0 when idle.
- `timeout`, output, 1: registered one-cycle pulse on a forced release.

## Operation

- State: 2-state FSM (IDLE, HOLD), rotating priority pointer `ptr` (IW bits), and an 8-bit hold counter `hcnt`.
- Reset (rst=1 at an edge) sets: `grant`=0, `grant_valid`=0, `grant_idx`=0, `timeout`=0, `ptr`=0, `hcnt`=0, state=IDLE. Reset overrides every other input, including mid-HOLD.
- IDLE with `req`=0: stay in IDLE; outputs stay 0.
- IDLE with `req`≠0:
  - Winner = first set bit found searching ascending from `ptr`, wrapping from N-1 to 0.
  - Next edge: `grant`=1<<winner, `grant_idx`=winner, `grant_valid`=1, `hcnt`=0, state=HOLD.
- HOLD:
  - Grant stays frozen. Changes on `req`, including a new request from the holder's own bit, are ignored.
  - Release condition: `release`=1, or `req[grant_idx]`=0 (requester withdrew).
  - On release: next edge clears `grant`, `grant_valid` and `grant_idx`; sets `ptr`=(grant_idx+1) mod N, wrapping at N-1 to 0, not at 2**IW; state=IDLE.
  - Otherwise `hcnt` increments, saturating at 255.
- Mandatory bubble: every grant is followed by at least one IDLE cycle with `grant`=0. Back-to-back requesters are therefore served every 2 cycles or more.
- `release` while in IDLE has no effect.
- Invariant: `grant` is never multi-hot and always agrees with `grant_idx`.

## Timing

- Request to grant: 1 cycle. `req` sampled at edge k gives `grant` valid after edge k.
- Release to grant drop: 1 cycle.
- Minimum grant length: 1 cycle, when `release`=1 in the first HOLD cycle.
- Fairness: a continuously asserted requester is granted within N grants.
- All outputs are registers; there is no combinational path from inputs to outputs.

## Configuration

- Macro: `RR_ARB_HOLD_TIMEOUT_EN`.
- Defined:
  - In HOLD, if `hcnt`==MAX_HOLD-1 and no release condition holds, the next edge forces the release.
  - The forced release has the same effects as a normal release (grant cleared, `ptr` advanced, IDLE), and `timeout`=1 for exactly that one cycle.
  - If a normal release and the limit occur in the same cycle, the release is normal and `timeout` stays 0.
- Not defined: no forced release; `hcnt` and the limit logic are omitted; `timeout` is tied to 0; `MAX_HOLD` is ignored.

## Test plan

- Reset and idle: hold `rst`=1 for 2 cycles, then `req`=0 for 5 cycles → `grant`=0, `grant_valid`=0, `grant_idx`=0, `timeout`=0 throughout.
- Single requester: `req`=16'h0004 → the next cycle shows `grant`=16'h0004, `grant_idx`=2. Pulse `release` → `grant`=0 the next cycle, then `grant`=16'h0004 again one cycle after that (bubble observed).
- Rotation and wrap: `req`=16'h8001 held, with each holder releasing after 1 cycle → grant order is 0x0001, 0x8000, 0x0001, 0x8000. `ptr` wraps from 15 to 0.
- Withdrawal and frozen grant:
  - While bit 5 is granted, raise `req[3]` → grant stays 0x0020.
  - Then drop `req[5]` → grant drops to 0, and the next grant is 0x0008 after the bubble.
- Reset mid-HOLD: bit 7 granted, then `rst`=1 for 1 cycle → all outputs 0, `ptr`=0. With `req`=16'h0081 the next grant is 0x0001.
- Timeout (macro defined, `MAX_HOLD`=4): bit 1 granted, `req[1]` held, `release`=0 → grant drops after 4 HOLD cycles and `timeout` pulses high for 1 cycle. Without the macro the grant is held indefinitely and `timeout` stays 0.

Source files
------------

// File: rtl/rr_arbiter16.sv
// rr_arbiter16: round-robin arbiter holding a registered one-hot grant.
// Optional forced release after MAX_HOLD cycles: define RR_ARB_HOLD_TIMEOUT_EN.
module rr_arbiter16 #(
  parameter int N        = 16,
  parameter int IW       = 4,
  parameter int MAX_HOLD = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          releaseHold,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx,
  output logic          timeout
);

  if (N < 2 || N > 16 || (1 << IW) < N ||
      MAX_HOLD < 1 || MAX_HOLD > 255) begin : gBadParam
    $error("rr_arbiter16: parameter out of range");
  end

  typedef enum logic {IDLE, HOLD} stateT;

  stateT         state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] winner;
  logic [IW-1:0] nextPtr;
  logic [IW:0]   sum;
  logic [2*N-1:0] reqRot;
  logic          found;
  logic          relCond;
  logic          atLimit;

  // Rotate so that bit 0 of reqRot is the requester at ptr.
  assign reqRot = {req, req} >> ptr;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && reqRot[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IW+1)'(i);
        if (sum >= (IW+1)'(N))
          sum = sum - (IW+1)'(N);
        winner = sum[IW-1:0];
      end
    end
  end

  assign relCond = releaseHold | ~|(req & grant);
  assign nextPtr = (grant_idx == IW'(N - 1)) ?
                   '0 : grant_idx + 1'b1;

`ifdef RR_ARB_HOLD_TIMEOUT_EN
  logic [7:0] hcnt;
  assign atLimit = (hcnt == 8'(MAX_HOLD - 1));
`else
  assign atLimit = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      ptr         <= '0;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
      hcnt        <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
`ifdef RR_ARB_HOLD_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (found) begin
            grant       <= N'(1) << winner;
            grant_idx   <= winner;
            grant_valid <= 1'b1;
            state       <= HOLD;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
            hcnt        <= '0;
`endif
          end
        end
        HOLD: begin
          if (relCond || atLimit) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            ptr         <= nextPtr;
            state       <= IDLE;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
            // A normal release in the same cycle wins over the limit.
            timeout     <= ~relCond;
`endif
          end
`ifdef RR_ARB_HOLD_TIMEOUT_EN
          else if (hcnt != 8'hFF) begin
            hcnt <= hcnt + 8'd1;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter16.sv
// tb_rr_arbiter16: directed and randomized checks of rr_arbiter16
// against a cycle-level behavioural model.
module tb_rr_arbiter16;

  localparam int N    = 16;
  localparam int IW   = 4;
  localparam int MAXH = 4;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic          rel = 1'b0;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic          timeout;

  int chk  = 0;
  int pass = 0;
  logic [21:0] exp;
  logic [21:0] got;

  assign got = {grant, grant_valid, grant_idx, timeout};

  always #5 clk = ~clk;

  rr_arbiter16 #(.N(N), .IW(IW), .MAX_HOLD(MAXH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .releaseHold (rel),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .timeout     (timeout)
  );

  // Behavioural model: who holds the grant, how long, where search starts.
  int mPtr  = 0;
  int mIdx  = 0;
  int mHcnt = 0;
  bit mHold = 0;
  bit mTo   = 0;
  bit mRel, mLim, mFound;

  always @(posedge clk) begin
    mTo = 0;
    if (rst) begin
      mHold = 0; mIdx = 0; mPtr = 0; mHcnt = 0;
    end else if (!mHold) begin
      mFound = 0;
      for (int k = 0; k < N; k++) begin
        if (!mFound && req[(mPtr + k) % N]) begin
          mFound = 1;
          mIdx = (mPtr + k) % N;
          mHold = 1;
          mHcnt = 0;
        end
      end
    end else begin
      mRel = rel || !req[mIdx];
      mLim = ToEn && (mHcnt == MAXH - 1);
      if (mRel || mLim) begin
        mTo = !mRel;
        mPtr = (mIdx + 1) % N;
        mHold = 0;
        mIdx = 0;
      end else if (mHcnt < 255) begin
        mHcnt++;
      end
    end
  end

  function automatic logic [21:0] modelOut();
    logic [15:0] g;
    g = mHold ? (16'h0001 << mIdx) : 16'h0000;
    return {g, mHold, 4'(mIdx), mTo};
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; req = '0; rel = 0;
    repeat (2) begin
      cyc();
      exp = '0;
      chk++;
      if (got !== exp) $display("FAIL reset got=%h exp=%h", got, exp);
      else pass++;
    end
    rst = 0;
    repeat (5) begin
      cyc();
      exp = '0;
      chk++;
      if (got !== exp) $display("FAIL idle got=%h exp=%h", got, exp);
      else pass++;
    end
  endtask

  task automatic test_single();
    req = 16'h0004;
    cyc();
    exp = {16'h0004, 1'b1, 4'd2, 1'b0};
    chk++;
    if (got !== exp) $display("FAIL single_grant got=%h exp=%h", got, exp);
    else pass++;
    rel = 1;
    cyc();
    rel = 0;
    exp = '0;
    chk++;
    if (got !== exp) $display("FAIL single_bubble got=%h exp=%h", got, exp);
    else pass++;
    cyc();
    exp = {16'h0004, 1'b1, 4'd2, 1'b0};
    chk++;
    if (got !== exp) $display("FAIL single_regrant got=%h exp=%h", got, exp);
    else pass++;
    req = '0;
    cyc();
    cyc();
  endtask

  task automatic test_rotation();
    logic [15:0] seq [7];
    seq = '{16'h0001, 16'h0000, 16'h8000, 16'h0000,
            16'h0001, 16'h0000, 16'h8000};
    rst = 1;
    cyc();
    rst = 0;
    req = 16'h8001;
    rel = 1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      exp = {seq[i], |seq[i], seq[i][15] ? 4'd15 : 4'd0, 1'b0};
      chk++;
      if (got !== exp) $display("FAIL rotate[%0d] got=%h exp=%h", i, got, exp);
      else pass++;
    end
    rel = 0;
    req = '0;
    cyc();
    cyc();
  endtask

  task automatic test_withdraw();
    req = 16'h0020;
    cyc();
    req = 16'h0028;
    repeat (2) begin
      cyc();
      exp = {16'h0020, 1'b1, 4'd5, 1'b0};
      chk++;
      if (got !== exp) $display("FAIL frozen got=%h exp=%h", got, exp);
      else pass++;
    end
    req = 16'h0008;
    cyc();
    exp = '0;
    chk++;
    if (got !== exp) $display("FAIL withdraw got=%h exp=%h", got, exp);
    else pass++;
    cyc();
    exp = {16'h0008, 1'b1, 4'd3, 1'b0};
    chk++;
    if (got !== exp) $display("FAIL after_wd got=%h exp=%h", got, exp);
    else pass++;
    req = '0;
    cyc();
    cyc();
  endtask

  task automatic test_reset_mid();
    req = 16'h0080;
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    exp = '0;
    chk++;
    if (got !== exp) $display("FAIL mid_reset got=%h exp=%h", got, exp);
    else pass++;
    req = 16'h0081;
    cyc();
    exp = {16'h0001, 1'b1, 4'd0, 1'b0};
    chk++;
    if (got !== exp) $display("FAIL ptr_reset got=%h exp=%h", got, exp);
    else pass++;
    req = '0;
    cyc();
    cyc();
  endtask

  task automatic test_timeout();
    req = 16'h0002;
    rel = 0;
    cyc();
    exp = {16'h0002, 1'b1, 4'd1, 1'b0};
    chk++;
    if (got !== exp) $display("FAIL to_grant got=%h exp=%h", got, exp);
    else pass++;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
    repeat (MAXH - 1) begin
      cyc();
      exp = {16'h0002, 1'b1, 4'd1, 1'b0};
      chk++;
      if (got !== exp) $display("FAIL to_hold got=%h exp=%h", got, exp);
      else pass++;
    end
    cyc();
    exp = {16'h0000, 1'b0, 4'd0, 1'b1};
    chk++;
    if (got !== exp) $display("FAIL to_pulse got=%h exp=%h", got, exp);
    else pass++;
    cyc();
    exp = {16'h0002, 1'b1, 4'd1, 1'b0};
    chk++;
    if (got !== exp) $display("FAIL to_regrant got=%h exp=%h", got, exp);
    else pass++;
`else
    repeat (20) begin
      cyc();
      exp = {16'h0002, 1'b1, 4'd1, 1'b0};
      chk++;
      if (got !== exp) $display("FAIL no_to_hold got=%h exp=%h", got, exp);
      else pass++;
    end
`endif
    req = '0;
    cyc();
    cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 9) < 3) begin
        if ($urandom_range(0, 9) == 0) req = '0;
        else req = 16'($urandom) & 16'($urandom);
      end
      rel = ($urandom_range(0, 3) == 0);
      cyc();
      exp = modelOut();
      chk++;
      if (got !== exp) $display("FAIL rand[%0d] got=%h exp=%h", i, got, exp);
      else pass++;
      chk++;
      if (!$onehot0(grant) || (grant_valid !== |grant) ||
          (grant_valid && grant !== (16'h0001 << grant_idx)))
        $display("FAIL onehot[%0d] got=%h", i, got);
      else pass++;
    end
    rst = 0;
    rel = 0;
    req = '0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_withdraw();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
